// File: rtl/oflow_core_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// oflow_core_seq_ctrl_if
//   Bundle of every handshake/command/status signal around the oflow core
//   frame/set sequencer. Clock and reset stay plain ports on the modules.
//
//   master : the sequencer (drives commands and status, receives strobes)
//   slave  : the surroundings (DMA front end, PE array, CR unit, MEM writer)
//
//   Signals
//     start, new_frame, abort        frame-level control into the sequencer
//     num_of_bbox_in_frame           bbox count of the incoming frame
//     new_set_from_dma/ready_new_set set handshake with the DMA
//     ready_new_frame                frame finished, next one may come
//     start_pe/active_pe/done_pe     PE array launch, enable count, done
//     start_cr/done_cr/conflict_over_th  conflict-resolve launch/result
//     start_write_mem/score, done_write, rnw_st  memory/score write
//     valid_id                       IDs of the frame are final
//     frame_num, num_of_sets, counter_of_remain_bboxes, cr_iter  status
//     busy, err_cr_drop              activity and frame-drop indication
// ---------------------------------------------------------------------------
interface oflow_core_seq_ctrl_if #(
  parameter int PE_NUM      = 24,
  parameter int MAX_BBOX    = 128,
  parameter int FRAME_W     = 8,
  parameter int CR_MAX_ITER = 3
);
  localparam int BBOX_W = $clog2(MAX_BBOX + 1);
  localparam int SET_W  = $clog2((MAX_BBOX + PE_NUM - 1) / PE_NUM + 1);
  localparam int PE_W   = $clog2(PE_NUM + 1);
  localparam int ITER_W = $clog2(CR_MAX_ITER + 1);

  logic              start;
  logic              new_frame;
  logic              abort;
  logic [BBOX_W-1:0] num_of_bbox_in_frame;
  logic              new_set_from_dma;
  logic              ready_new_set;
  logic              ready_new_frame;
  logic              start_pe;
  logic [PE_W-1:0]   active_pe;
  logic              done_pe;
  logic              start_cr;
  logic              done_cr;
  logic              conflict_over_th;
  logic              start_write_mem;
  logic              start_write_score;
  logic              done_write;
  logic              rnw_st;
  logic              valid_id;
  logic [FRAME_W-1:0] frame_num;
  logic [SET_W-1:0]  num_of_sets;
  logic [BBOX_W-1:0] counter_of_remain_bboxes;
  logic [ITER_W-1:0] cr_iter;
  logic              busy;
  logic              err_cr_drop;

  modport master (
    input  start, new_frame, abort, num_of_bbox_in_frame, new_set_from_dma,
           done_pe, done_cr, conflict_over_th, done_write,
    output ready_new_set, ready_new_frame, start_pe, active_pe, start_cr,
           start_write_mem, start_write_score, rnw_st, valid_id, frame_num,
           num_of_sets, counter_of_remain_bboxes, cr_iter, busy, err_cr_drop
  );

  modport slave (
    output start, new_frame, abort, num_of_bbox_in_frame, new_set_from_dma,
           done_pe, done_cr, conflict_over_th, done_write,
    input  ready_new_set, ready_new_frame, start_pe, active_pe, start_cr,
           start_write_mem, start_write_score, rnw_st, valid_id, frame_num,
           num_of_sets, counter_of_remain_bboxes, cr_iter, busy, err_cr_drop
  );
endinterface

// File: rtl/oflow_core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// oflow_core_seq_ctrl
//   Frame/set sequencer of the oflow core. For each frame it splits the bbox
//   count into PE-sized sets, handshakes every set with the DMA, runs the PE
//   array once per set, runs conflict resolution (bounded retries) on every
//   frame but frame 0, then fires the memory/score write and the ID release.
//   A frame whose conflicts stay above threshold after CR_MAX_ITER passes is
//   dropped (err_cr_drop). abort returns to IDLE holding all counters.
//
//   Ports
//     clk      clock
//     reset_N  asynchronous active-low reset
//     bus      oflow_core_seq_ctrl_if.master (all handshakes and status)
//
//   Every output is a register; command pulses are one cycle wide and appear
//   in the first cycle of the state they lead into.
// ---------------------------------------------------------------------------
module oflow_core_seq_ctrl #(
  parameter int PE_NUM      = 24,
  parameter int MAX_BBOX    = 128,
  parameter int FRAME_W     = 8,
  parameter int CR_MAX_ITER = 3
) (
  input  logic                   clk,
  input  logic                   reset_N,
  oflow_core_seq_ctrl_if.master  bus
);
  localparam int BBOX_W = $clog2(MAX_BBOX + 1);
  localparam int SET_W  = $clog2((MAX_BBOX + PE_NUM - 1) / PE_NUM + 1);
  localparam int PE_W   = $clog2(PE_NUM + 1);
  localparam int ITER_W = $clog2(CR_MAX_ITER + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SET_REQ = 3'd2,
    S_PE_WAIT = 3'd3,
    S_CR      = 3'd4,
    S_WRITE   = 3'd5
  } state_t;

  // Saturate an incoming bbox count to the frame maximum.
  function automatic logic [BBOX_W-1:0] clamp_bbox(input logic [BBOX_W-1:0] n);
    if (32'(n) > MAX_BBOX) return BBOX_W'(MAX_BBOX);
    return n;
  endfunction

  // Number of PE-sized sets needed for n bboxes (ceiling division).
  function automatic logic [SET_W-1:0] ceil_sets(input logic [BBOX_W-1:0] n);
    return SET_W'((32'(n) + PE_NUM - 1) / PE_NUM);
  endfunction

  // PEs to enable for the next set: whatever is left, at most PE_NUM.
  function automatic logic [PE_W-1:0] min_pe(input logic [BBOX_W-1:0] r);
    if (32'(r) < PE_NUM) return PE_W'(r);
    return PE_W'(PE_NUM);
  endfunction

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [SET_W-1:0]   sets_q, sets_d;
  logic [SET_W-1:0]   sets_done_q, sets_done_d;
  logic [BBOX_W-1:0]  remain_q, remain_d;
  logic [PE_W-1:0]    active_q, active_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               rdy_set_q, rdy_set_d;
  logic               rdy_frame_q, rdy_frame_d;
  logic               start_pe_q, start_pe_d;
  logic               start_cr_q, start_cr_d;
  logic               start_wr_q, start_wr_d;
  logic               valid_id_q, valid_id_d;
  logic               err_q, err_d;
  logic               rnw_q, rnw_d;
  logic               busy_q, busy_d;

  logic [BBOX_W-1:0]  n_clamped;
  logic [SET_W-1:0]   sets_done_inc;
  logic               handshake;
  logic               cr_retry_ok;

  assign n_clamped     = clamp_bbox(bus.num_of_bbox_in_frame);
  assign sets_done_inc = sets_done_q + SET_W'(1);
  // ready_new_set is only ever high in SET_REQ, so it doubles as the state
  // qualifier for the DMA handshake.
  assign handshake     = rdy_set_q & bus.new_set_from_dma;
  assign cr_retry_ok   = (iter_q < ITER_W'(CR_MAX_ITER));

  // State register plus all registered outputs and counters.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      sets_q      <= '0;
      sets_done_q <= '0;
      remain_q    <= '0;
      active_q    <= '0;
      iter_q      <= '0;
      rdy_set_q   <= 1'b0;
      rdy_frame_q <= 1'b0;
      start_pe_q  <= 1'b0;
      start_cr_q  <= 1'b0;
      start_wr_q  <= 1'b0;
      valid_id_q  <= 1'b0;
      err_q       <= 1'b0;
      rnw_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      sets_q      <= sets_d;
      sets_done_q <= sets_done_d;
      remain_q    <= remain_d;
      active_q    <= active_d;
      iter_q      <= iter_d;
      rdy_set_q   <= rdy_set_d;
      rdy_frame_q <= rdy_frame_d;
      start_pe_q  <= start_pe_d;
      start_cr_q  <= start_cr_d;
      start_wr_q  <= start_wr_d;
      valid_id_q  <= valid_id_d;
      err_q       <= err_d;
      rnw_q       <= rnw_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (bus.start || bus.new_frame) state_d = S_LOAD;
        S_LOAD:    state_d = (n_clamped == '0) ? S_WRITE : S_SET_REQ;
        S_SET_REQ: if (handshake) state_d = S_PE_WAIT;
        S_PE_WAIT: begin
          if (bus.done_pe) begin
            if (sets_done_inc < sets_q) state_d = S_SET_REQ;
            else if (frame_q == '0)     state_d = S_WRITE;
            else                        state_d = S_CR;
          end
        end
        S_CR: begin
          if (bus.done_cr) begin
            if (!bus.conflict_over_th) state_d = S_WRITE;
            else if (!cr_retry_ok)     state_d = S_IDLE;
          end
        end
        S_WRITE:   if (bus.done_write) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output and counter updates. Under abort nothing but the levels derived
  // from state_d moves, so pulses are suppressed and counters hold.
  always_comb begin
    frame_d     = frame_q;
    sets_d      = sets_q;
    sets_done_d = sets_done_q;
    remain_d    = remain_q;
    active_d    = active_q;
    iter_d      = iter_q;
    rdy_frame_d = 1'b0;
    start_pe_d  = 1'b0;
    start_cr_d  = 1'b0;
    start_wr_d  = 1'b0;
    valid_id_d  = 1'b0;
    err_d       = 1'b0;

    if (!bus.abort) begin
      case (state_q)
        S_IDLE: begin
          // start wins over new_frame and restarts the frame count.
          if (bus.start) frame_d = '0;
        end
        S_LOAD: begin
          sets_d      = ceil_sets(n_clamped);
          remain_d    = n_clamped;
          sets_done_d = '0;
          iter_d      = '0;
          if (n_clamped == '0) begin
            // Empty frame: straight to the write, IDs final unless frame 0.
            start_wr_d = 1'b1;
            valid_id_d = (frame_q != '0);
          end
        end
        S_SET_REQ: begin
          if (handshake) begin
            active_d   = min_pe(remain_q);
            start_pe_d = 1'b1;
          end
        end
        S_PE_WAIT: begin
          if (bus.done_pe) begin
            remain_d    = remain_q - BBOX_W'(active_q);
            sets_done_d = sets_done_inc;
            if (sets_done_inc >= sets_q) begin
              if (frame_q == '0) begin
                start_wr_d = 1'b1;
              end else begin
                start_cr_d = 1'b1;
                iter_d     = ITER_W'(1);
              end
            end
          end
        end
        S_CR: begin
          if (bus.done_cr) begin
            if (!bus.conflict_over_th) begin
              valid_id_d = 1'b1;
              start_wr_d = 1'b1;
            end else if (cr_retry_ok) begin
              start_cr_d = 1'b1;
              iter_d     = iter_q + ITER_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus.done_write) begin
            rdy_frame_d = 1'b1;
            frame_d     = frame_q + FRAME_W'(1);
          end
        end
        default: ;
      endcase
    end

    rdy_set_d = (state_d == S_SET_REQ);
    busy_d    = (state_d != S_IDLE);
    rnw_d     = (state_d != S_WRITE);
  end

  assign bus.ready_new_set            = rdy_set_q;
  assign bus.ready_new_frame          = rdy_frame_q;
  assign bus.start_pe                 = start_pe_q;
  assign bus.active_pe                = active_q;
  assign bus.start_cr                 = start_cr_q;
  assign bus.start_write_mem          = start_wr_q;
  assign bus.start_write_score        = start_wr_q;
  assign bus.rnw_st                   = rnw_q;
  assign bus.valid_id                 = valid_id_q;
  assign bus.frame_num                = frame_q;
  assign bus.num_of_sets              = sets_q;
  assign bus.counter_of_remain_bboxes = remain_q;
  assign bus.cr_iter                  = iter_q;
  assign bus.busy                     = busy_q;
  assign bus.err_cr_drop              = err_q;

endmodule

// File: tb/tb_oflow_core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oflow_core_seq_ctrl
//   Frame-level bench for the oflow core sequencer. A procedural frame model
//   drives each frame (random delays, ignored stray strobes, random bbox
//   counts and CR outcomes) and keeps the outputs the sequencer must show in
//   every cycle; one negedge process compares all outputs against it. A few
//   literal expectations from the worked examples pin the model itself.
// ---------------------------------------------------------------------------
module tb_oflow_core_seq_ctrl;
  localparam int PE_NUM      = 24;
  localparam int MAX_BBOX    = 128;
  localparam int FRAME_W     = 2;
  localparam int CR_MAX_ITER = 3;
  localparam int BBOX_W      = $clog2(MAX_BBOX + 1);

  logic clk = 1'b0;
  logic reset_N = 1'b0;

  oflow_core_seq_ctrl_if #(.PE_NUM(PE_NUM), .MAX_BBOX(MAX_BBOX),
                           .FRAME_W(FRAME_W), .CR_MAX_ITER(CR_MAX_ITER)) bus ();

  oflow_core_seq_ctrl #(.PE_NUM(PE_NUM), .MAX_BBOX(MAX_BBOX),
                        .FRAME_W(FRAME_W), .CR_MAX_ITER(CR_MAX_ITER)) dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs for the current cycle.
  bit exp_rdy_set, exp_rnf, exp_pe, exp_cr, exp_wr, exp_vid, exp_err;
  bit exp_rnw, exp_busy;
  int exp_active, exp_frame, exp_sets, exp_remain, exp_iter;

  // Pulse tallies and log of active_pe seen at each start_pe.
  int cnt_pe = 0, cnt_cr = 0, cnt_wr = 0, cnt_vid = 0, cnt_rnf = 0, cnt_err = 0;
  int act_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic reset_exp();
    exp_rdy_set = 0; exp_rnf = 0; exp_pe = 0; exp_cr = 0; exp_wr = 0;
    exp_vid = 0; exp_err = 0; exp_rnw = 1; exp_busy = 0;
    exp_active = 0; exp_frame = 0; exp_sets = 0; exp_remain = 0; exp_iter = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_new_set",     32'(bus.ready_new_set),     32'(exp_rdy_set));
      check("ready_new_frame",   32'(bus.ready_new_frame),   32'(exp_rnf));
      check("start_pe",          32'(bus.start_pe),          32'(exp_pe));
      check("active_pe",         32'(bus.active_pe),         exp_active);
      check("start_cr",          32'(bus.start_cr),          32'(exp_cr));
      check("start_write_mem",   32'(bus.start_write_mem),   32'(exp_wr));
      check("start_write_score", 32'(bus.start_write_score), 32'(exp_wr));
      check("rnw_st",            32'(bus.rnw_st),            32'(exp_rnw));
      check("valid_id",          32'(bus.valid_id),          32'(exp_vid));
      check("frame_num",         32'(bus.frame_num),         exp_frame);
      check("num_of_sets",       32'(bus.num_of_sets),       exp_sets);
      check("remain_bboxes",     32'(bus.counter_of_remain_bboxes), exp_remain);
      check("cr_iter",           32'(bus.cr_iter),           exp_iter);
      check("busy",              32'(bus.busy),              32'(exp_busy));
      check("err_cr_drop",       32'(bus.err_cr_drop),       32'(exp_err));
      if (bus.start_pe === 1'b1) begin cnt_pe++; act_log.push_back(int'(bus.active_pe)); end
      if (bus.start_cr === 1'b1)        cnt_cr++;
      if (bus.start_write_mem === 1'b1) cnt_wr++;
      if (bus.valid_id === 1'b1)        cnt_vid++;
      if (bus.ready_new_frame === 1'b1) cnt_rnf++;
      if (bus.err_cr_drop === 1'b1)     cnt_err++;
    end
  end

  // One clock: strobes drop, expected pulses drop; the caller then states
  // what the new cycle must show.
  task automatic step();
    @(posedge clk); #1;
    bus.start = 0; bus.new_frame = 0; bus.abort = 0; bus.new_set_from_dma = 0;
    bus.done_pe = 0; bus.done_cr = 0; bus.done_write = 0;
    exp_pe = 0; exp_cr = 0; exp_wr = 0; exp_vid = 0; exp_rnf = 0; exp_err = 0;
  endtask

  // Wait n cycles, randomly raising strobes the current state must ignore.
  // ok[0]=new_set_from_dma ok[1]=done_pe ok[2]=done_cr ok[3]=done_write
  task automatic idle_wait(input int n, input logic [3:0] ok);
    for (int i = 0; i < n; i++) begin
      if (ok[0] && $urandom_range(0, 3) == 0) bus.new_set_from_dma = 1;
      if (ok[1] && $urandom_range(0, 3) == 0) bus.done_pe = 1;
      if (ok[2] && $urandom_range(0, 3) == 0) bus.done_cr = 1;
      if (ok[3] && $urandom_range(0, 3) == 0) bus.done_write = 1;
      step();
    end
  endtask

  // One frame. nfail = number of CR passes reporting conflicts before a
  // clean one (>= CR_MAX_ITER means the frame is dropped).
  task automatic run_frame(input int n_in, input int nfail, input bit use_start,
                           input int first_wait, input bit do_abort, input bit do_rst);
    int n, sets, act;
    idle_wait($urandom_range(0, 2), 4'b1111);
    bus.num_of_bbox_in_frame = BBOX_W'(n_in);
    if (use_start) begin
      bus.start = 1;
      bus.new_frame = 1'($urandom_range(0, 1));
    end else begin
      bus.new_frame = 1;
    end
    step();
    exp_busy = 1;
    if (use_start) exp_frame = 0;
    step();
    bus.num_of_bbox_in_frame = BBOX_W'($urandom);
    n    = (n_in > MAX_BBOX) ? MAX_BBOX : n_in;
    sets = (n + PE_NUM - 1) / PE_NUM;
    exp_sets = sets; exp_remain = n; exp_iter = 0;
    if (n == 0) begin
      exp_wr = 1; exp_rnw = 0; exp_vid = (exp_frame != 0);
    end else begin
      exp_rdy_set = 1;
      for (int s = 0; s < sets; s++) begin
        idle_wait((s == 0 && first_wait >= 0) ? first_wait : $urandom_range(0, 3), 4'b1110);
        bus.new_set_from_dma = 1;
        step();
        act = (exp_remain < PE_NUM) ? exp_remain : PE_NUM;
        exp_pe = 1; exp_active = act; exp_rdy_set = 0;
        idle_wait($urandom_range(0, 3), 4'b1101);
        if (do_abort) begin
          bus.abort = 1;
          bus.done_pe = 1'($urandom_range(0, 1));
          step();
          exp_busy = 0;
          bus.done_pe = 1;
          step();
          return;
        end
        bus.done_pe = 1;
        step();
        exp_remain -= act;
        if (s + 1 < sets) exp_rdy_set = 1;
      end
      if (exp_frame == 0) begin
        exp_wr = 1; exp_rnw = 0;
      end else begin
        exp_cr = 1; exp_iter = 1;
        for (int p = 1; p <= CR_MAX_ITER; p++) begin
          if (do_rst) begin
            #2 reset_N = 0;
            #1;
            check("rst_busy",      32'(bus.busy),        0);
            check("rst_frame_num", 32'(bus.frame_num),   0);
            check("rst_rnw_st",    32'(bus.rnw_st),      1);
            check("rst_start_cr",  32'(bus.start_cr),    0);
            check("rst_num_sets",  32'(bus.num_of_sets), 0);
            check("rst_active_pe", 32'(bus.active_pe),   0);
            reset_exp();
            step();
            reset_N = 1;
            return;
          end
          idle_wait($urandom_range(0, 3), 4'b1011);
          bus.conflict_over_th = (p <= nfail);
          bus.done_cr = 1;
          step();
          if (p > nfail) begin
            exp_vid = 1; exp_wr = 1; exp_rnw = 0;
            break;
          end else if (p < CR_MAX_ITER) begin
            exp_cr = 1; exp_iter = p + 1;
          end else begin
            exp_err = 1; exp_busy = 0;
            return;
          end
        end
      end
    end
    idle_wait($urandom_range(0, 3), 4'b0111);
    bus.done_write = 1;
    step();
    exp_rnf = 1; exp_rnw = 1; exp_busy = 0;
    exp_frame = (exp_frame + 1) % (1 << FRAME_W);
  endtask

  int s_pe, s_cr, s_wr, s_vid, s_rnf, s_err;
  task automatic snap();
    s_pe = cnt_pe; s_cr = cnt_cr; s_wr = cnt_wr;
    s_vid = cnt_vid; s_rnf = cnt_rnf; s_err = cnt_err;
    act_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.new_frame = 0; bus.abort = 0; bus.num_of_bbox_in_frame = '0;
    bus.new_set_from_dma = 0; bus.done_pe = 0; bus.done_cr = 0;
    bus.conflict_over_th = 0; bus.done_write = 0;
    reset_exp();
    chk_en = 1;
    #23;
    check("reset_frame_num", 32'(bus.frame_num), 0);
    check("reset_rnw_st",    32'(bus.rnw_st),    1);
    check("reset_busy",      32'(bus.busy),      0);
    reset_N = 1;

    // Frame 0, n=50, DMA withholds the first set for 10 cycles.
    snap();
    run_frame(50, 0, 1, 10, 0, 0);
    step();
    check("f0_start_pe_count", cnt_pe - s_pe, 3);
    check("f0_active_0", (act_log.size() > 0) ? act_log[0] : -1, 24);
    check("f0_active_1", (act_log.size() > 1) ? act_log[1] : -1, 24);
    check("f0_active_2", (act_log.size() > 2) ? act_log[2] : -1, 2);
    check("f0_start_cr_count", cnt_cr - s_cr, 0);
    check("f0_ready_new_frame", cnt_rnf - s_rnf, 1);
    check("f0_frame_num_after", 32'(bus.frame_num), 1);

    // Frame 1, n=24, clean CR.
    snap();
    run_frame(24, 0, 0, -1, 0, 0);
    step();
    check("f1_start_cr_count", cnt_cr - s_cr, 1);
    check("f1_active", (act_log.size() > 0) ? act_log[0] : -1, 24);
    check("f1_valid_id_count", cnt_vid - s_vid, 1);
    check("f1_write_count", cnt_wr - s_wr, 1);

    // Frame 2, conflicts never clear: dropped after CR_MAX_ITER passes.
    snap();
    run_frame(30, 5, 0, -1, 0, 0);
    step();
    check("drop_start_cr_count", cnt_cr - s_cr, 3);
    check("drop_err_count", cnt_err - s_err, 1);
    check("drop_write_count", cnt_wr - s_wr, 0);
    check("drop_frame_num", 32'(bus.frame_num), 2);

    // Frame 2 again, empty.
    snap();
    run_frame(0, 0, 0, -1, 0, 0);
    step();
    check("empty_start_pe_count", cnt_pe - s_pe, 0);
    check("empty_valid_id_count", cnt_vid - s_vid, 1);
    check("empty_frame_num", 32'(bus.frame_num), 3);

    // Frame 3, n=200 clamps to 128; one retry; frame number wraps.
    snap();
    run_frame(200, 1, 0, -1, 0, 0);
    step();
    check("clamp_start_pe_count", cnt_pe - s_pe, 6);
    check("clamp_last_active", (act_log.size() > 5) ? act_log[5] : -1, 8);
    check("clamp_start_cr_count", cnt_cr - s_cr, 2);
    check("wrap_frame_num", 32'(bus.frame_num), 0);

    // Abort in PE_WAIT, then a late done_pe.
    snap();
    run_frame(40, 0, 0, -1, 1, 0);
    step();
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_write_count", cnt_wr - s_wr, 0);
    check("abort_frame_num", 32'(bus.frame_num), 0);

    // Empty frame 0: no valid_id.
    snap();
    run_frame(0, 0, 0, -1, 0, 0);
    step();
    check("empty_f0_valid_id_count", cnt_vid - s_vid, 0);
    check("empty_f0_write_count", cnt_wr - s_wr, 1);

    // Reset asserted in CR.
    run_frame(10, 0, 0, -1, 0, 1);
    step();
    check("after_rst_frame_num", 32'(bus.frame_num), 0);

    // Stray done_write in IDLE.
    snap();
    bus.done_write = 1;
    step();
    step();
    check("stray_done_write_rnf", cnt_rnf - s_rnf, 0);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      run_frame($urandom_range(0, 140), $urandom_range(0, 4),
                ($urandom_range(0, 7) == 0), -1, ($urandom_range(0, 15) == 0), 0);
    end
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/oflow_core_seq_ctrl.md
# oflow_core_seq_ctrl

Parametrised frame/set sequencer for the oflow core, placed between the DMA front end and the PE array, conflict-resolve unit and MEM buffer writer. Per frame it splits the bounding-box count into PE-sized sets and handshakes each set with the DMA. It runs the PE array once per set, runs conflict resolution with a bounded retry count on every frame except frame 0, then triggers the memory/score write and the ID release. Compared with the previous core FSM it adds a generic PE count, a per-set active-PE count, empty-frame handling, a CR retry limit with frame drop, a synchronous abort and a busy/error status.

## Interface
Parameters:
- PE_NUM, 24, number of physical PEs (bboxes per set), ≥1
- MAX_BBOX, 128, maximum bboxes per frame
- FRAME_W, 8, frame counter width (wraps)
- CR_MAX_ITER, 3, maximum conflict-resolve passes per frame, ≥1
- Derived: BBOX_W = $clog2(MAX_BBOX+1), SET_W = $clog2(ceil(MAX_BBOX/PE_NUM)+1), PE_W = $clog2(PE_NUM+1), ITER_W = $clog2(CR_MAX_ITER+1)

Ports:
- clk  in  1  clock
- reset_N  in  1  asynchronous, active-low reset
- start  in  1  begin sequence; clears frame_num
- new_frame  in  1  next frame available from DMA
- abort  in  1  synchronous abort to IDLE
- num_of_bbox_in_frame  in  BBOX_W  bbox count, sampled in LOAD
- new_set_from_dma  in  1  DMA set valid
- ready_new_set  out  1  level; block accepts a set
- ready_new_frame  out  1  pulse; frame finished, next frame may come
- start_pe  out  1  pulse; launch PE array
- active_pe  out  PE_W  PEs enabled for the current set, held through PE_WAIT
- done_pe  in  1  PE array finished the set
- start_cr  out  1  pulse; launch conflict resolve
- done_cr  in  1  CR pass finished
- conflict_over_th  in  1  sampled with done_cr; conflicts remain above threshold
- start_write_mem  out  1  pulse
- start_write_score  out  1  pulse, coincident with start_write_mem
- done_write  in  1  write finished
- rnw_st  out  1  0 in WRITE, else 1
- valid_id  out  1  pulse; IDs of the frame are final
- frame_num  out  FRAME_W  current frame index
- num_of_sets  out  SET_W  ceil(n/PE_NUM), latched in LOAD
- counter_of_remain_bboxes  out  BBOX_W  bboxes not yet processed
- cr_iter  out  ITER_W  CR passes done in the current frame
- busy  out  1  state ≠ IDLE
- err_cr_drop  out  1  pulse; frame dropped after CR_MAX_ITER passes

## Operation
- States: IDLE, LOAD, SET_REQ, PE_WAIT, CR, WRITE.
- IDLE
  - start → frame_num := 0, go to LOAD.
  - new_frame alone → LOAD.
  - start and new_frame together: treated as start.
- LOAD (1 cycle)
  - Latch n = num_of_bbox_in_frame. num_of_sets := ceil(n/PE_NUM); remain := n; sets_done := 0; cr_iter := 0.
  - n = 0 → WRITE, pulsing start_write_mem/score. No PE or CR run; valid_id pulses only if frame_num ≠ 0.
  - n > MAX_BBOX → clamp to MAX_BBOX.
  - Otherwise → SET_REQ.
- SET_REQ
  - ready_new_set = 1.
  - Handshake = ready_new_set & new_set_from_dma.
  - On handshake: active_pe := min(remain, PE_NUM), pulse start_pe, go to PE_WAIT.
- PE_WAIT
  - On done_pe: remain -= active_pe; sets_done += 1.
  - sets_done (new value) < num_of_sets → SET_REQ.
  - All sets done and frame_num = 0 → pulse start_write_mem/score, go to WRITE.
  - All sets done and frame_num ≠ 0 → pulse start_cr, cr_iter := 1, go to CR.
- CR
  - On done_cr with conflict_over_th = 0 → pulse valid_id and start_write_mem/score, go to WRITE.
  - On done_cr with conflict_over_th = 1 and cr_iter < CR_MAX_ITER → pulse start_cr, cr_iter += 1.
  - On done_cr with conflict_over_th = 1 and cr_iter = CR_MAX_ITER → pulse err_cr_drop, go to IDLE. No write; frame_num unchanged.
- WRITE
  - On done_write: pulse ready_new_frame, frame_num += 1 (mod 2^FRAME_W), go to IDLE.
- abort: from any state, next state is IDLE. All pulses are suppressed that cycle. frame_num, num_of_sets and counters are held.
- Strobes arriving in a state that does not expect them (done_pe, done_cr, done_write, new_set_from_dma) are ignored.

## Timing
- All outputs are registered.
- Reset values: frame_num = 0, num_of_sets = 0, counter_of_remain_bboxes = 0, active_pe = 0, cr_iter = 0, rnw_st = 1, and every other output 0. State resets to IDLE.
- Command pulses are exactly 1 cycle wide and are asserted in the first cycle of the destination state.
- Latencies:
  - start/new_frame in cycle k → LOAD in k+1 → ready_new_set high in k+2.
  - Handshake in cycle k → start_pe and new active_pe in k+1; ready_new_set low from k+1.
  - done_pe in cycle k → ready_new_set in k+1 (next set), or start_cr / start_write in k+1.
  - done_cr in cycle k → start_cr retry, or valid_id + start_write, in k+1.
  - done_write in cycle k → ready_new_frame and frame_num+1 in k+1; new_frame is accepted from k+1.
- Reset asserted mid-frame: immediate return to reset values with no pulses.

## Test plan
- PE_NUM=24, frame 0 with n=50: 3 handshakes, active_pe = 24, 24, 2; no start_cr. After done_write, frame_num = 1 and ready_new_frame pulses once.
- Frame 1 with n=24: one set with active_pe = 24, then start_cr. done_cr with conflict_over_th = 0 → valid_id and start_write_mem in the same cycle.
- CR_MAX_ITER=3, conflict_over_th held at 1: exactly 3 start_cr pulses, then err_cr_drop, IDLE, frame_num unchanged, no write pulse.
- n=0 on frame 2: LOAD → WRITE directly; no start_pe; valid_id pulses once. FRAME_W=2 with frame_num=3 → wraps to 0.
- new_set_from_dma held low for 10 cycles in SET_REQ → ready_new_set stays 1 with no start_pe. abort in PE_WAIT → IDLE next cycle, busy = 0, and a late done_pe is ignored.
- reset_N dropped during CR → all outputs at reset values asynchronously. A stray done_write in IDLE → no response.
